// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding,
// button-priority decode values, count limit and BCD digit limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    // Result of the same-cycle button arbitration (clear > load > start > lap)
    typedef enum logic [2:0] {
        BTN_NONE  = 3'd0,
        BTN_CLEAR = 3'd1,
        BTN_LOAD  = 3'd2,
        BTN_START = 3'd3,
        BTN_LAP   = 3'd4
    } btn_e;

    localparam logic [15:0] SW_MAX_COUNT = 16'h5999;

    localparam logic [3:0] DIG_A_MAX = 4'd9;
    localparam logic [3:0] DIG_B_MAX = 4'd9;
    localparam logic [3:0] DIG_C_MAX = 4'd9;
    localparam logic [2:0] DIG_D_MAX = 3'd5;

    // True when every digit of the {d[2:0],c,b,a} preset is within its range
    function automatic logic bcd_load_ok(input logic [14:0] v);
        return (v[3:0]   <= DIG_A_MAX) &&
               (v[7:4]   <= DIG_B_MAX) &&
               (v[11:8]  <= DIG_C_MAX) &&
               (v[14:12] <= DIG_D_MAX);
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Bundle of button, counter-chain and display signals around the stopwatch
// controller. The controller side uses the slave modport.
interface stopwatch_if;

    logic        btn_start;
    logic        btn_clear;
    logic        btn_load;
    logic        btn_lap;
    logic        dir;
    logic [14:0] load_value;
    logic [15:0] count_bcd;
    logic        tick_en;
    logic        cnt_clear;
    logic        cnt_load;
    logic [15:0] load_bcd;
    logic        load_err;
    logic        running;
    logic        lap_hold;
    logic [15:0] disp_bcd;
    logic [1:0]  state;

    modport master (
        output btn_start, btn_clear, btn_load, btn_lap, dir, load_value, count_bcd,
        input  tick_en, cnt_clear, cnt_load, load_bcd, load_err, running, lap_hold,
               disp_bcd, state
    );

    modport slave (
        input  btn_start, btn_clear, btn_load, btn_lap, dir, load_value, count_bcd,
        output tick_en, cnt_clear, cnt_load, load_bcd, load_err, running, lap_hold,
               disp_bcd, state
    );

endinterface

// File: rtl/stopwatch_tick_prescaler.sv
// Free-running divider for the count tick. o_tc is a registered flag that is
// high exactly while the counter sits at its terminal value TICK_DIV-1, so the
// controller can act on the terminal cycle itself.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned DIV_W    = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam logic [DIV_W-1:0] TERM = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_next;
    logic             r_tc;

    // Next counter value: wrap to zero after the terminal value
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_cnt == TERM) begin
            w_cnt_next = {DIV_W{1'b0}};
        end else begin
            w_cnt_next = r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter and terminal flag; clear beats enable, otherwise hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {DIV_W{1'b0}};
            r_tc  <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= {DIV_W{1'b0}};
            r_tc  <= (TERM == {DIV_W{1'b0}});
        end else if (i_en) begin
            r_cnt <= w_cnt_next;
            r_tc  <= (w_cnt_next == TERM);
        end else begin
            r_cnt <= r_cnt;
            r_tc  <= r_tc;
        end
    end

    assign o_tc = r_tc;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: arbitrates the debounced buttons, sequences the BCD
// counter chain (tick/clear/load strobes), detects the count limit and holds a
// lap value for the display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1_000_000,
    parameter int unsigned DIV_W     = 20,
    parameter logic [15:0] MAX_COUNT = SW_MAX_COUNT
) (
    input  logic         clk100,
    input  logic         reset_n,
    stopwatch_if.slave   sw
);

    sw_state_e   r_state;
    logic        r_tick_en;
    logic        r_cnt_clear;
    logic        r_cnt_load;
    logic [15:0] r_load_bcd;
    logic        r_load_err;
    logic        r_running;
    logic        r_lap_hold;
    logic [15:0] r_lap_reg;

    btn_e        w_btn;
    logic        w_load_ok;
    logic [15:0] w_limit;
    logic        w_presc_en;
    logic        w_presc_clr;
    logic        w_tc;

    // Same-cycle button arbitration: only the highest-priority press acts
    always_comb begin
        w_btn = BTN_NONE;
        if (sw.btn_clear) begin
            w_btn = BTN_CLEAR;
        end else if (sw.btn_load) begin
            w_btn = BTN_LOAD;
        end else if (sw.btn_start) begin
            w_btn = BTN_START;
        end else if (sw.btn_lap) begin
            w_btn = BTN_LAP;
        end else begin
            w_btn = BTN_NONE;
        end
    end

    // Limit depends on direction; checked against the live count at terminal count
    always_comb begin
        w_load_ok = bcd_load_ok(sw.load_value);
        if (sw.dir) begin
            w_limit = 16'h0000;
        end else begin
            w_limit = MAX_COUNT;
        end
    end

    // Prescaler runs only in RUN and stops on the cycle a pause or clear is taken;
    // it is kept at zero outside RUN/PAUSE so a fresh start begins a full period
    always_comb begin
        w_presc_en  = 1'b0;
        w_presc_clr = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_presc_en  = (w_btn != BTN_CLEAR) && (w_btn != BTN_START);
                w_presc_clr = (w_btn == BTN_CLEAR);
            end
            ST_PAUSE: begin
                w_presc_en  = 1'b0;
                w_presc_clr = 1'b0;
            end
            default: begin
                w_presc_en  = 1'b0;
                w_presc_clr = 1'b1;
            end
        endcase
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .i_clk   (clk100),
        .i_rst_n (reset_n),
        .i_en    (w_presc_en),
        .i_clr   (w_presc_clr),
        .o_tc    (w_tc)
    );

    // Main FSM with registered strobes, lap register and load checker
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_tick_en   <= 1'b0;
            r_cnt_clear <= 1'b0;
            r_cnt_load  <= 1'b0;
            r_load_bcd  <= 16'h0000;
            r_load_err  <= 1'b0;
            r_running   <= 1'b0;
            r_lap_hold  <= 1'b0;
            r_lap_reg   <= 16'h0000;
        end else begin
            r_tick_en   <= 1'b0;
            r_cnt_clear <= 1'b0;
            r_cnt_load  <= 1'b0;
            r_load_err  <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    case (w_btn)
                        BTN_CLEAR: begin
                            r_cnt_clear <= 1'b1;
                            r_lap_hold  <= 1'b0;
                        end
                        BTN_START: begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end
                        default: begin
                            // load is ignored while running; lap toggles capture
                            if (w_btn == BTN_LAP) begin
                                if (r_lap_hold) begin
                                    r_lap_hold <= 1'b0;
                                end else begin
                                    r_lap_reg  <= sw.count_bcd;
                                    r_lap_hold <= 1'b1;
                                end
                            end
                            if (w_tc) begin
                                if (sw.count_bcd == w_limit) begin
                                    r_state   <= ST_DONE;
                                    r_running <= 1'b0;
                                end else begin
                                    r_tick_en <= 1'b1;
                                end
                            end
                        end
                    endcase
                end
                ST_IDLE, ST_PAUSE, ST_DONE: begin
                    case (w_btn)
                        BTN_CLEAR: begin
                            r_cnt_clear <= 1'b1;
                            r_lap_hold  <= 1'b0;
                            r_state     <= ST_IDLE;
                            r_running   <= 1'b0;
                        end
                        BTN_LOAD: begin
                            if (w_load_ok) begin
                                r_cnt_load <= 1'b1;
                                r_load_bcd <= {1'b0, sw.load_value};
                                r_lap_hold <= 1'b0;
                                r_state    <= ST_IDLE;
                                r_running  <= 1'b0;
                            end else begin
                                r_load_err <= 1'b1;
                            end
                        end
                        BTN_START: begin
                            // DONE only leaves via clear or load
                            if (r_state != ST_DONE) begin
                                r_state   <= ST_RUN;
                                r_running <= 1'b1;
                            end
                        end
                        BTN_LAP: begin
                            if (r_lap_hold) begin
                                r_lap_hold <= 1'b0;
                            end
                        end
                        default: begin
                            r_state <= r_state;
                        end
                    endcase
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign sw.tick_en   = r_tick_en;
    assign sw.cnt_clear = r_cnt_clear;
    assign sw.cnt_load  = r_cnt_load;
    assign sw.load_bcd  = r_load_bcd;
    assign sw.load_err  = r_load_err;
    assign sw.running   = r_running;
    assign sw.lap_hold  = r_lap_hold;
    assign sw.state     = r_state;
    assign sw.disp_bcd  = r_lap_hold ? r_lap_reg : sw.count_bcd;

endmodule
